// File: rtl/cac_data_slice.sv
// Cache data slice: WAYS x 2^ADR_BITS words of WIDTH data bits plus one odd-parity bit,
// with registered replicated read data, single-word writes and a wrapping line-refill sequencer.
module cac_data_slice #(
    parameter int unsigned WAYS      = 4,
    parameter int unsigned WIDTH     = 9,
    parameter int unsigned ADR_BITS  = 9,
    parameter int unsigned LINE_BITS = 2,
    parameter int unsigned REPL      = 3,
    parameter int unsigned PAR_GEN   = 1
) (
    input  logic                    clk_h,
    input  logic                    crobar_h,
    input  logic [ADR_BITS-1:0]     cache_adr_h,
    input  logic [WAYS-1:0]         way_sel_l,
    input  logic                    csh_en_csh_data_l,
    input  logic                    cache_wr_l,
    input  logic [WIDTH-1:0]        mem_to_cache_h,
    input  logic                    csh_par_bit_in_h,
    input  logic                    mem_valid_h,
    input  logic                    fill_start_h,
    output logic [REPL*WIDTH-1:0]   cache_data_h,
    output logic [REPL-1:0]         csh_par_bit_h,
    output logic                    csh_par_err_h,
    output logic                    fill_busy_h,
    output logic                    fill_done_h
);

    localparam int unsigned DEPTH  = 1 << ADR_BITS;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned BASE_W = ADR_BITS - LINE_BITS;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    // Lowest-index asserted (low) way select; 0 when none asserted.
    function automatic logic [WAY_W-1:0] low_way(input logic [WAYS-1:0] sel_l);
        low_way = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (!sel_l[i]) low_way = WAY_W'(i);
        end
    endfunction

    logic [WIDTH:0]          mem [WAYS][DEPTH];

    state_t                  state, state_nx;
    logic [BASE_W-1:0]       base, base_nx;
    logic [WAY_W-1:0]        fway, fway_nx;
    logic [LINE_BITS-1:0]    cnt, cnt_nx;
    logic [LINE_BITS-1:0]    beat, beat_nx;

    logic                    any_sel_c;
    logic [WAY_W-1:0]        rd_way_c;
    logic [WAYS-1:0]         wr_en_c;
    logic [ADR_BITS-1:0]     wr_adr_c;
    logic                    wr_par_c;
    logic [WIDTH:0]          wr_word_c;
    logic                    rd_hit_c;
    logic [WIDTH:0]          rd_word_c;

    assign any_sel_c = ~&way_sel_l;
    assign rd_way_c  = low_way(way_sel_l);
    assign wr_par_c  = (PAR_GEN != 0) ? ~^mem_to_cache_h : csh_par_bit_in_h;
    assign wr_word_c = {wr_par_c, mem_to_cache_h};

    // Write-first read: forward the word being written when it targets the read location.
    assign rd_hit_c  = wr_en_c[rd_way_c] && (wr_adr_c == cache_adr_h);
    assign rd_word_c = rd_hit_c ? wr_word_c : mem[rd_way_c][cache_adr_h];

    // Refill sequencer next-state and write-port control.
    always_comb begin
        state_nx = state;
        base_nx  = base;
        fway_nx  = fway;
        cnt_nx   = cnt;
        beat_nx  = beat;
        wr_en_c  = '0;
        wr_adr_c = cache_adr_h;
        case (state)
            S_IDLE: begin
                if (!cache_wr_l) wr_en_c = ~way_sel_l;
                if (fill_start_h && any_sel_c) begin
                    base_nx  = cache_adr_h[ADR_BITS-1:LINE_BITS];
                    fway_nx  = rd_way_c;
                    cnt_nx   = cache_adr_h[LINE_BITS-1:0];
                    beat_nx  = '0;
                    state_nx = S_FILL;
                end
            end
            S_FILL: begin
                wr_adr_c = {base, cnt};
                if (mem_valid_h) begin
                    wr_en_c[fway] = 1'b1;
                    cnt_nx        = LINE_BITS'(cnt + 1'b1);
                    beat_nx       = LINE_BITS'(beat + 1'b1);
                    if (&beat) state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM and refill bookkeeping registers.
    always_ff @(posedge clk_h or posedge crobar_h) begin
        if (crobar_h) begin
            state       <= S_IDLE;
            base        <= '0;
            fway        <= '0;
            cnt         <= '0;
            beat        <= '0;
            fill_busy_h <= 1'b0;
            fill_done_h <= 1'b0;
        end else begin
            state       <= state_nx;
            base        <= base_nx;
            fway        <= fway_nx;
            cnt         <= cnt_nx;
            beat        <= beat_nx;
            fill_busy_h <= (state_nx == S_FILL);
            fill_done_h <= (state_nx == S_DONE);
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk_h) begin
        for (int w = 0; w < int'(WAYS); w++) begin
            if (wr_en_c[w]) mem[w][wr_adr_c] <= wr_word_c;
        end
    end

    // Registered, replicated read data with parity check.
    always_ff @(posedge clk_h or posedge crobar_h) begin
        if (crobar_h) begin
            cache_data_h  <= '0;
            csh_par_bit_h <= '0;
            csh_par_err_h <= 1'b0;
        end else if (!csh_en_csh_data_l && any_sel_c) begin
            cache_data_h  <= {REPL{rd_word_c[WIDTH-1:0]}};
            csh_par_bit_h <= {REPL{rd_word_c[WIDTH]}};
            csh_par_err_h <= ~^rd_word_c;
        end else begin
            cache_data_h  <= '0;
            csh_par_bit_h <= '0;
            csh_par_err_h <= 1'b0;
        end
    end

endmodule
